// File: rtl/vm2002_change_dispenser.sv
// Coin-return unit: pays a change amount greedily (quarter, dime, nickel), one coin per handshake, tracking tube counts.
// Latency: accept -> SELECT next cycle -> first coin valid the cycle after; done pulses 2 cycles after the final ack.
// Backpressure: each coin is held stable until coin_out_ack; new requests are only taken while change_ready (IDLE).
module vm2002_change_dispenser #(
  parameter int unsigned NICKEL_INIT  = 8,
  parameter int unsigned DIME_INIT    = 8,
  parameter int unsigned QUARTER_INIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       change_valid,
  input  logic [7:0] change_amount,
  output logic       change_ready,
  output logic       coin_out_valid,
  output logic [1:0] coin_out,
  input  logic       coin_out_ack,
  input  logic       coin_in_valid,
  input  logic [1:0] coin_in,
  input  logic       restock,
  output logic       done,
  output logic       short_change,
  output logic [7:0] remainder,
  output logic [3:0] nickel_count,
  output logic [3:0] dime_count,
  output logic [3:0] quarter_count
);

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  localparam logic [3:0] N_INIT = 4'(NICKEL_INIT);
  localparam logic [3:0] D_INIT = 4'(DIME_INIT);
  localparam logic [3:0] Q_INIT = 4'(QUARTER_INIT);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

  state_t     state;
  logic [7:0] rem;
  logic [1:0] pick;

  function automatic logic [7:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_NICKEL:  return 8'd5;
      COIN_DIME:    return 8'd10;
      COIN_QUARTER: return 8'd25;
      default:      return 8'd0;
    endcase
  endfunction

  // Saturating up-count; a simultaneous deposit and payout of the same tube cancel out.
  function automatic logic [3:0] tube_next(input logic [3:0] cnt, input logic inc, input logic dec);
    if (inc && !dec)      return (cnt == 4'd15) ? cnt : cnt + 4'd1;
    else if (dec && !inc) return cnt - 4'd1;
    else                  return cnt;
  endfunction

  assign change_ready = (state == IDLE);

  // Greedy choice for the current remainder; COIN_NONE means nothing more can be paid.
  always_comb begin
    pick = COIN_NONE;
    if (rem >= 8'd25 && quarter_count != 4'd0)   pick = COIN_QUARTER;
    else if (rem >= 8'd10 && dime_count != 4'd0) pick = COIN_DIME;
    else if (rem >= 8'd5 && nickel_count != 4'd0) pick = COIN_NICKEL;
  end

  // Payout sequencer with registered coin and completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rem            <= 8'd0;
      coin_out_valid <= 1'b0;
      coin_out       <= COIN_NONE;
      done           <= 1'b0;
      short_change   <= 1'b0;
      remainder      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          done         <= 1'b0;
          short_change <= 1'b0;
          remainder    <= 8'd0;
          if (change_valid) begin
            rem   <= change_amount;
            state <= SELECT;
          end
        end
        SELECT: begin
          if (rem == 8'd0 || pick == COIN_NONE) begin
            done         <= 1'b1;
            short_change <= (rem != 8'd0);
            remainder    <= rem;
            state        <= DONE;
          end else begin
            coin_out_valid <= 1'b1;
            coin_out       <= pick;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (coin_out_ack) begin
            coin_out_valid <= 1'b0;
            coin_out       <= COIN_NONE;
            rem            <= rem - coin_value(coin_out);
            state          <= SELECT;
          end
        end
        DONE: begin
          done         <= 1'b0;
          short_change <= 1'b0;
          remainder    <= 8'd0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic ack_take;
  logic restock_take;
  assign ack_take     = (state == ISSUE) && coin_out_ack;
  assign restock_take = (state == IDLE) && restock;

  // Tube counts: restock (IDLE only) wins, otherwise deposits and acked payouts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nickel_count  <= N_INIT;
      dime_count    <= D_INIT;
      quarter_count <= Q_INIT;
    end else if (restock_take) begin
      nickel_count  <= N_INIT;
      dime_count    <= D_INIT;
      quarter_count <= Q_INIT;
    end else begin
      nickel_count  <= tube_next(nickel_count,
                                 coin_in_valid && coin_in == COIN_NICKEL,
                                 ack_take && coin_out == COIN_NICKEL);
      dime_count    <= tube_next(dime_count,
                                 coin_in_valid && coin_in == COIN_DIME,
                                 ack_take && coin_out == COIN_DIME);
      quarter_count <= tube_next(quarter_count,
                                 coin_in_valid && coin_in == COIN_QUARTER,
                                 ack_take && coin_out == COIN_QUARTER);
    end
  end

endmodule
